// File: rtl/csa_mul_pkg.sv
// Shared state encodings and cycle-count helper for the carry-save multiplier.
package csa_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    function automatic int ncyc(input int w, input int rows);
        return (w + rows - 1) / rows;
    endfunction

endpackage

// File: rtl/csa_compress.sv
// Combinational N-input to sum/carry reducer: N-2 chained 3:2 layers.
module csa_compress #(
    parameter int N   = 4,
    parameter int WID = 22
) (
    input  logic [N*WID-1:0] in_flat,
    output logic [WID-1:0]   sum,
    output logic [WID-1:0]   carry
);

    for (genvar k = 0; k < N - 2; k++) begin : g_l
        logic [WID-1:0] si;
        logic [WID-1:0] ci;
        logic [WID-1:0] x;
        logic [WID-1:0] maj;
        logic [WID-1:0] s;
        logic [WID-1:0] c;
        if (k == 0) begin : g_first
            assign si = in_flat[0 +: WID];
            assign ci = in_flat[WID +: WID];
        end else begin : g_next
            assign si = g_l[k-1].s;
            assign ci = g_l[k-1].c;
        end
        assign x   = in_flat[(k+2)*WID +: WID];
        assign s   = si ^ ci ^ x;
        assign maj = (si & ci) | (si & x) | (ci & x);
        // Carry weight is one bit up; the top carry falls off mod 2^WID.
        assign c   = maj << 1;
    end

    assign sum   = g_l[N-3].s;
    assign carry = g_l[N-3].c;

endmodule

// File: rtl/csa_seq_multiplier.sv
// Iterative unsigned multiplier: ROWS partial products per cycle into a CSA pair.
// Optional sticky output enabled by defining CSA_STICKY_EN.
module csa_seq_multiplier
    import csa_mul_pkg::*;
#(
    parameter int W    = 11,
    parameter int ROWS = 2
`ifdef CSA_STICKY_EN
    ,
    parameter int STL  = 10
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
`ifdef CSA_STICKY_EN
    ,
    output logic           sticky
`endif
);

    localparam int PW   = 2 * W;
    localparam int NCYC = ncyc(W, ROWS);
    localparam int CW   = $clog2(NCYC) + 1;
    localparam int N    = ROWS + 2;

    state_e          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PW-1:0]   sum_q, sum_d;
    logic [PW-1:0]   carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic [PW-1:0]   resolved;
    logic [N*PW-1:0] comp_in;
    logic [PW-1:0]   comp_sum;
    logic [PW-1:0]   comp_carry;

    // a/b shift each cycle so row j always sees weight cnt*ROWS+j.
    always_comb begin
        comp_in = '0;
        comp_in[0 +: PW]  = sum_q;
        comp_in[PW +: PW] = carry_q;
        for (int j = 0; j < ROWS; j++) begin
            comp_in[(j+2)*PW +: PW] = b_q[j] ? (a_q << j) : '0;
        end
    end

    csa_compress #(
        .N   (N),
        .WID (PW)
    ) u_compress (
        .in_flat (comp_in),
        .sum     (comp_sum),
        .carry   (comp_carry)
    );

    assign resolved = sum_q + carry_q;

`ifdef CSA_STICKY_EN
    logic sticky_q, sticky_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef CSA_STICKY_EN
        sticky_d  = sticky_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = PW'(a);
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sum_d   = comp_sum;
                carry_d = comp_carry;
                a_d     = a_q << ROWS;
                b_d     = b_q >> ROWS;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCYC - 1)) state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                product_d = resolved;
`ifdef CSA_STICKY_EN
                sticky_d  = |resolved[STL-1:0];
`endif
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

`ifdef CSA_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Randomised self-checking bench: two instances (ROWS=2 and ROWS=3) vs a*b.
module tb_csa_seq_multiplier;

    localparam int W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          iv1 = 0, ir1, ov1, or1 = 0;
    logic [W-1:0]  a1 = '0, b1 = '0;
    logic [21:0]   p1;
    logic          iv2 = 0, ir2, ov2, or2 = 0;
    logic [W-1:0]  a2 = '0, b2 = '0;
    logic [21:0]   p2;
`ifdef CSA_STICKY_EN
    logic          st1, st2;
`endif

    int checks = 0;
    int failures = 0;
    int sel = 0;

    csa_seq_multiplier #(.W(W), .ROWS(2)
`ifdef CSA_STICKY_EN
        , .STL(10)
`endif
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .product(p1)
`ifdef CSA_STICKY_EN
        , .sticky(st1)
`endif
    );

    csa_seq_multiplier #(.W(W), .ROWS(3)
`ifdef CSA_STICKY_EN
        , .STL(10)
`endif
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .product(p2)
`ifdef CSA_STICKY_EN
        , .sticky(st2)
`endif
    );

    wire        ov_s = sel ? ov2 : ov1;
    wire        ir_s = sel ? ir2 : ir1;
    wire [21:0] p_s  = sel ? p2 : p1;

    function automatic logic [21:0] ref_mul(input int unsigned x, input int unsigned y);
        longint unsigned r;
        r = longint'(x) * longint'(y);
        return r[21:0];
    endfunction

    // Drive one op on instance `sel`; returns cycles from accept edge to out_valid.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [21:0] prod);
        @(negedge clk);
        if (sel == 0) begin iv1 = 1; a1 = x; b1 = y; or1 = 0; end
        else          begin iv2 = 1; a2 = x; b2 = y; or2 = 0; end
        @(negedge clk);
        iv1 = 0; iv2 = 0;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        lat = 0;
        while (!ov_s && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        prod = p_s;
    endtask

    task automatic release_op();
        or1 = 1; or2 = 1;
        @(negedge clk);
        or1 = 0; or2 = 0;
    endtask

    task automatic op_check(input string nm, input logic [W-1:0] x,
                            input logic [W-1:0] y, input int elat);
        int lat;
        logic [21:0] prod;
        logic [21:0] exp;
        exp = ref_mul(x, y);
        run_op(x, y, lat, prod);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", nm, lat, elat);
        end
        checks++;
        if (prod !== exp) begin
            failures++;
            $display("FAIL %s product got=%0d exp=%0d", nm, prod, exp);
        end
        release_op();
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++;
        if (ov1 !== 0 || p1 !== '0 || ov2 !== 0 || p2 !== '0) begin
            failures++;
            $display("FAIL reset ov=%b p=%0d exp ov=0 p=0", ov1, p1);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1 || ir2 !== 1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b exp=11", ir1, ir2);
        end
    endtask

    task automatic test_directed();
        sel = 0;
        op_check("max", 11'd2047, 11'd2047, 7);
        op_check("pow2", 11'd1024, 11'd1024, 7);
        op_check("zero", 11'd0, 11'd1234, 7);
        op_check("one", 11'd1, 11'd2047, 7);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [21:0] prod;
        sel = 0;
        run_op(11'd1500, 11'd777, lat, prod);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ov1 !== 1 || ir1 !== 0 || p1 !== ref_mul(1500, 777)) begin
                failures++;
                $display("FAIL hold ov=%b ir=%b p=%0d exp ov=1 ir=0 p=%0d",
                         ov1, ir1, p1, ref_mul(1500, 777));
            end
        end
        release_op();
        checks++;
        if (ov1 !== 0 || ir1 !== 1) begin
            failures++;
            $display("FAIL release ov=%b ir=%b exp ov=0 ir=1", ov1, ir1);
        end
        op_check("after_hold", 11'd99, 11'd101, 7);
    endtask

    task automatic test_midreset();
        sel = 0;
        @(negedge clk);
        iv1 = 1; a1 = 11'd1000; b1 = 11'd1000;
        @(negedge clk);
        iv1 = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (ov1 !== 0 || p1 !== '0) begin
            failures++;
            $display("FAIL midreset ov=%b p=%0d exp ov=0 p=0", ov1, p1);
        end
        @(negedge clk);
        rst_n = 1;
        op_check("post_reset", 11'd3, 11'd5, 7);
    endtask

    task automatic test_rows3();
        sel = 1;
        op_check("r3_1365", 11'd1365, 11'd1365, 5);
        op_check("r3_max", 11'd2047, 11'd2047, 5);
        for (int i = 0; i < 300; i++) begin
            op_check("r3_rand", W'($urandom), W'($urandom), 5);
        end
        sel = 0;
    endtask

`ifdef CSA_STICKY_EN
    task automatic test_sticky();
        int lat;
        logic [21:0] prod;
        logic [W-1:0] x, y;
        logic [21:0] e;
        sel = 0;
        for (int i = 0; i < 202; i++) begin
            x = (i == 0) ? 11'd3 : (i == 1) ? 11'd1024 : W'($urandom);
            y = (i == 0) ? 11'd1 : (i == 1) ? 11'd1024 : W'($urandom);
            e = ref_mul(x, y);
            run_op(x, y, lat, prod);
            checks++;
            if (st1 !== (e[9:0] != 0)) begin
                failures++;
                $display("FAIL sticky a=%0d b=%0d got=%b exp=%b", x, y, st1, e[9:0] != 0);
            end
            release_op();
        end
    endtask
`endif

    task automatic test_random();
        sel = 0;
        for (int i = 0; i < 1500; i++) begin
            op_check("rand", W'($urandom), W'($urandom), 7);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midreset();
        test_rows3();
`ifdef CSA_STICKY_EN
        test_sticky();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
